execute: RTL
============

# execute

Execute stage of the five-stage Y86-64 pipeline, directly downstream of decode. Consumes the E pipeline register (written by decode), computes the ALU result, keeps the condition codes, and evaluates jump/cmov conditions. Drives the forwarding outputs `e_dstE`/`e_valE` back to decode and registers its results into the M pipeline register for memory.

## Interface
Parameters: none (widths fixed by ISA: data 64, reg id 4, icode/ifun 4, stat 3).

- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `E_stat`  in  3  status of instruction in E
- `E_icode`, `E_ifun`  in  4 each  instruction code / function
- `E_valA`, `E_valB`, `E_valC`  in  64 each  operands from decode
- `E_dstE`, `E_dstM`  in  4 each  destination regs (4'hF = none)
- `m_stat`  in  3  status currently leaving memory stage
- `W_stat`  in  3  status in W register
- `M_bubble`  in  1  inject bubble into M on this edge
- `e_valE`  out  64  combinational ALU result (forwarding)
- `e_dstE`  out  4  combinational effective dstE (forwarding)
- `e_Cnd`  out  1  combinational condition result
- `ZF`, `SF`, `OF`  out  1 each  condition-code register
- `M_stat`  out  3, `M_icode`  out  4, `M_Cnd`  out  1, `M_valE`, `M_valA`  out  64 each, `M_dstE`, `M_dstM`  out  4 each  — M pipeline register

## Operation
- Stat codes: AOK=1, HLT=2, ADR=3, INS=4.
- aluA: rrmovq/cmovXX(2), OPq(6) → valA; irmovq(3), rmmovq(4), mrmovq(5) → valC; call(8), push(A) → −8; ret(9), pop(B) → +8; otherwise 0.
- aluB: rmmovq, mrmovq, OPq, call, ret, push, pop → valB; cmovXX, irmovq → 0; otherwise 0.
- alufun: OPq → ifun (0 add B+A, 1 sub B−A, 2 and, 3 xor; ifun>3 → add); all others add.
- Flags from ALU: ZF = result==0; SF = result[63]; OF add: A[63]==B[63] && R[63]!=A[63]; OF sub: B[63]!=A[63] && R[63]!=B[63]; OF=0 for and/xor. Arithmetic is modulo 2^64.
- set_cc = (E_icode==OPq) && m_stat==AOK && W_stat==AOK. CC register loads flags only when set_cc.
- Condition (uses current CC register, not this cycle's flags), by ifun: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; 7–F → 0. e_Cnd meaningful for icode 2 and 7; computed for all.
- e_dstE = 4'hF if E_icode==cmovXX and !e_Cnd, else E_dstE.
- M register load (normal): M_stat←E_stat, M_icode←E_icode, M_Cnd←e_Cnd, M_valE←e_valE, M_valA←E_valA, M_dstE←e_dstE, M_dstM←E_dstM.
- Bubble value: M_stat=AOK, M_icode=NOP(1), M_Cnd=0, M_valE=M_valA=0, M_dstE=M_dstM=4'hF.

## Timing
- e_valE, e_dstE, e_Cnd: zero latency, combinational from E inputs and CC.
- M register and CC: one rising edge of latency.
- Reset (rst_n=0 at edge): M register ← bubble value; ZF=1, SF=0, OF=0. Reset dominates M_bubble and set_cc. Reset mid-stream discards the instruction in E.
- M_bubble=1 (rst_n=1): M ← bubble value; CC still updates if set_cc (bubble gates M only; hazard control deasserts set_cc path via m_stat/W_stat).
- OPq followed by jXX/cmovXX next cycle sees the updated CC.
- Exception in m_stat or W_stat blocks CC update the same edge.

## Structure
- Shared package `y86_pkg`: icode constants (HALT..POPQ), stat codes, RNONE=4'hF, ALU function codes, condition function codes, bubble constants.
- Sub-module `alu`: combinational 64-bit ALU (aluA, aluB, alufun → result, zf, sf, of). Execute instantiates it and owns CC, condition logic, and M register.

## Test plan
- Reset: rst_n=0 one edge → M_icode=1, M_stat=1, M_dstE=M_dstM=F, ZF=1, SF=0, OF=0.
- OPq add: valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, dstE=3 → e_valE=0x8000_0000_0000_0000, next edge SF=1, OF=1, ZF=0, M_dstE=3.
- sub equal then cmove: OPq ifun1 valA=valB=5 → ZF=1; next cycle cmovXX ifun3 dstE=2 → e_Cnd=1, e_dstE=2; then ifun4 → e_dstE=F.
- push/pop: push valB=0x100 → e_valE=0xF8; pop valB=0xF8 → e_valE=0x100; call and ret likewise.
- set_cc gating: OPq giving zero with m_stat=ADR → CC unchanged; same with W_stat=HLT → unchanged; both AOK → ZF=1.
- M_bubble=1 during irmovq valC=42 → M holds bubble values; asserting rst_n=0 with M_bubble=1 and OPq → CC reset to ZF=1, SF=0, OF=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline: instruction codes, status codes,
// ALU and condition function codes, and the M-register bubble value.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fun_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] BUBBLE_STAT  = SAOK;
    localparam logic [3:0] BUBBLE_ICODE = INOP;

    function automatic logic condEval(input logic [3:0] ifun, input logic zf,
                                      input logic sf, input logic of);
        logic res;
        res = 1'b0;
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit Y86 ALU: computes B op A and the flags that result
// would set; whether the flags are kept is decided by the execute stage.
module alu
    import y86_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  alu_fun_e    fun_i,
    output logic [63:0] result_o,
    output logic        zf_o,
    output logic        sf_o,
    output logic        of_o
);

    logic [63:0] sum;
    logic [63:0] diff;

    assign sum  = b_i + a_i;
    assign diff = b_i - a_i;

    always_comb begin
        result_o = sum;
        of_o     = 1'b0;
        case (fun_i)
            ALU_ADD: begin
                result_o = sum;
                of_o     = (a_i[63] == b_i[63]) && (sum[63] != a_i[63]);
            end
            ALU_SUB: begin
                result_o = diff;
                of_o     = (b_i[63] != a_i[63]) && (diff[63] != b_i[63]);
            end
            ALU_AND: result_o = b_i & a_i;
            ALU_XOR: result_o = b_i ^ a_i;
            default: result_o = sum;
        endcase
    end

    assign zf_o = (result_o == 64'd0);
    assign sf_o = result_o[63];

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register,
// jump/cmov condition evaluation and the M pipeline register.
module execute
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic        ZF,
    output logic        SF,
    output logic        OF,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
);

    logic [63:0] aluA;
    logic [63:0] aluB;
    alu_fun_e    aluFun;
    logic        aluZf, aluSf, aluOf;
    logic        setCc;

    logic        ccZf_q, ccSf_q, ccOf_q;
    logic [2:0]  mStat_q, mStat_d;
    logic [3:0]  mIcode_q, mIcode_d;
    logic        mCnd_q, mCnd_d;
    logic [63:0] mValE_q, mValE_d;
    logic [63:0] mValA_q, mValA_d;
    logic [3:0]  mDstE_q, mDstE_d;
    logic [3:0]  mDstM_q, mDstM_d;

    always_comb begin
        aluA = 64'd0;
        case (E_icode)
            IRRMOVQ, IOPQ:             aluA = E_valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: aluA = E_valC;
            ICALL, IPUSHQ:             aluA = -64'sd8;
            IRET, IPOPQ:               aluA = 64'd8;
            default:                   aluA = 64'd0;
        endcase
    end

    always_comb begin
        aluB = 64'd0;
        case (E_icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: aluB = E_valB;
            default:                                            aluB = 64'd0;
        endcase
    end

    // Undefined OPq function codes fall back to add.
    assign aluFun = (E_icode != IOPQ) ? ALU_ADD :
                    (E_ifun > 4'd3)   ? ALU_ADD : alu_fun_e'(E_ifun[1:0]);

    alu u_alu (
        .a_i      (aluA),
        .b_i      (aluB),
        .fun_i    (aluFun),
        .result_o (e_valE),
        .zf_o     (aluZf),
        .sf_o     (aluSf),
        .of_o     (aluOf)
    );

    // Conditions read the stored flags, so an OPq one cycle ahead is visible.
    assign e_Cnd  = condEval(E_ifun, ccZf_q, ccSf_q, ccOf_q);
    assign e_dstE = ((E_icode == IRRMOVQ) && !e_Cnd) ? RNONE : E_dstE;
    assign setCc  = (E_icode == IOPQ) && (m_stat == SAOK) && (W_stat == SAOK);

    always_comb begin
        mStat_d  = E_stat;
        mIcode_d = E_icode;
        mCnd_d   = e_Cnd;
        mValE_d  = e_valE;
        mValA_d  = E_valA;
        mDstE_d  = e_dstE;
        mDstM_d  = E_dstM;
        if (M_bubble) begin
            mStat_d  = BUBBLE_STAT;
            mIcode_d = BUBBLE_ICODE;
            mCnd_d   = 1'b0;
            mValE_d  = 64'd0;
            mValA_d  = 64'd0;
            mDstE_d  = RNONE;
            mDstM_d  = RNONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mStat_q  <= BUBBLE_STAT;
            mIcode_q <= BUBBLE_ICODE;
            mCnd_q   <= 1'b0;
            mValE_q  <= 64'd0;
            mValA_q  <= 64'd0;
            mDstE_q  <= RNONE;
            mDstM_q  <= RNONE;
            ccZf_q   <= 1'b1;
            ccSf_q   <= 1'b0;
            ccOf_q   <= 1'b0;
        end else begin
            mStat_q  <= mStat_d;
            mIcode_q <= mIcode_d;
            mCnd_q   <= mCnd_d;
            mValE_q  <= mValE_d;
            mValA_q  <= mValA_d;
            mDstE_q  <= mDstE_d;
            mDstM_q  <= mDstM_d;
            if (setCc) begin
                ccZf_q <= aluZf;
                ccSf_q <= aluSf;
                ccOf_q <= aluOf;
            end
        end
    end

    assign ZF      = ccZf_q;
    assign SF      = ccSf_q;
    assign OF      = ccOf_q;
    assign M_stat  = mStat_q;
    assign M_icode = mIcode_q;
    assign M_Cnd   = mCnd_q;
    assign M_valE  = mValE_q;
    assign M_valA  = mValA_q;
    assign M_dstE  = mDstE_q;
    assign M_dstM  = mDstM_q;

endmodule
